// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABILIZE  = 3'd2,
    RUN        = 3'd3,
    FAIL       = 3'd4
  } pll_seq_state_t;

  localparam int unsigned LOSS_CNT_W = 8;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= 1'b0;
      o_q    <= 1'b0;
    end else begin
      meta_q <= i_d;
      o_q    <= meta_q;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses PLL reset, qualifies lock, releases the
// downstream reset, retries on timeout and re-sequences on lock loss.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES     = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 64,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 4096,
  parameter int unsigned MAX_RETRIES         = 3,
  localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_locked,
  input  logic                  i_restart,
  output logic                  o_pll_reset,
  output logic                  o_sys_rst_n,
  output logic                  o_ready,
  output logic                  o_error,
  output logic [RETRY_W-1:0]    o_retry_count,
  output logic [LOSS_CNT_W-1:0] o_lock_loss_count
);

  localparam int unsigned CNT_MAX = max3(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES,
                                         LOCK_TIMEOUT_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  pll_seq_state_t          state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [RETRY_W-1:0]      retry_q, retry_d;
  logic [LOSS_CNT_W-1:0]   loss_q, loss_d;
  logic                    pll_reset_q, pll_reset_d;
  logic                    sys_rst_n_q, sys_rst_n_d;
  logic                    ready_q, ready_d;
  logic                    error_q, error_d;
  logic                    locked_s;

  sync_2ff u_lock_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_locked),
    .o_q     (locked_s)
  );

  // Next state; outputs decode from state_d so they move on the transition edge.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    cnt_d   = cnt_q + CNT_W'(1);

    if (i_restart) begin
      state_d = RESET_HOLD;
      retry_d = '0;
    end else begin
      case (state_q)
        RESET_HOLD: begin
          if (cnt_q >= CNT_W'(RST_HOLD_CYCLES - 1)) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = STABILIZE;
          end else if (cnt_q >= CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
            if (retry_q < RETRY_W'(MAX_RETRIES)) begin
              retry_d = retry_q + RETRY_W'(1);
              state_d = RESET_HOLD;
            end else begin
              state_d = FAIL;
            end
          end
        end
        STABILIZE: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
          end else if (cnt_q >= CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_d = RESET_HOLD;
            retry_d = '0;
            if (loss_q != '1) loss_d = loss_q + LOSS_CNT_W'(1);
          end
        end
        FAIL:    state_d = FAIL;
        default: state_d = RESET_HOLD;
      endcase
    end

    // The counter is only meaningful while dwelling in a timed state.
    if (i_restart || (state_d != state_q) || (state_q == RUN) || (state_q == FAIL)) begin
      cnt_d = '0;
    end

    pll_reset_d = (state_d == RESET_HOLD) || (state_d == FAIL);
    sys_rst_n_d = (state_d == RUN);
    ready_d     = (state_d == RUN);
    error_d     = (state_d == FAIL);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= RESET_HOLD;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
    end
  end

  assign o_pll_reset       = pll_reset_q;
  assign o_sys_rst_n       = sys_rst_n_q;
  assign o_ready           = ready_q;
  assign o_error           = error_q;
  assign o_retry_count     = retry_q;
  assign o_lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer at default parameters.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       restart;
  logic       o_pll_reset, o_sys_rst_n, o_ready, o_error;
  logic [1:0] o_retry_count;
  logic [7:0] o_lock_loss_count;

  typedef struct packed {
    logic       pll;
    logic       sys;
    logic       rdy;
    logic       err;
    logic [1:0] retry;
    logic [7:0] loss;
  } exp_t;

  typedef struct {
    logic        locked;
    logic        restart;
    int unsigned ncyc;
    exp_t        exp;
  } vec_t;

  vec_t vecs[32];
  int   n_vec;
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_locked          (locked),
    .i_restart         (restart),
    .o_pll_reset       (o_pll_reset),
    .o_sys_rst_n       (o_sys_rst_n),
    .o_ready           (o_ready),
    .o_error           (o_error),
    .o_retry_count     (o_retry_count),
    .o_lock_loss_count (o_lock_loss_count)
  );

  function automatic exp_t mk(input bit pll, input bit sys, input bit rdy, input bit err,
                              input int retry, input int loss);
    exp_t e;
    e.pll   = pll;
    e.sys   = sys;
    e.rdy   = rdy;
    e.err   = err;
    e.retry = 2'(retry);
    e.loss  = 8'(loss);
    return e;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pop the oldest expectation and compare it with what the DUT shows now.
  task automatic compare(input string nm);
    exp_t e, act;
    act = {o_pll_reset, o_sys_rst_n, o_ready, o_error, o_retry_count, o_lock_loss_count};
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got pll=%0b sys=%0b rdy=%0b err=%0b retry=%0d loss=%0d, want pll=%0b sys=%0b rdy=%0b err=%0b retry=%0d loss=%0d",
                 nm, act.pll, act.sys, act.rdy, act.err, act.retry, act.loss,
                 e.pll, e.sys, e.rdy, e.err, e.retry, e.loss);
      end
    end
  endtask

  task automatic expect_now(input string nm, input exp_t e);
    sb_q.push_back(e);
    compare(nm);
  endtask

  task automatic add_vec(input bit lk, input bit rs, input int unsigned n, input exp_t e);
    vecs[n_vec] = '{lk, rs, n, e};
    n_vec++;
  endtask

  // Called just after the edge that entered RESET_HOLD with retry 0; lock held high.
  task automatic bring_up(input int loss);
    locked = 1'b1;
    cyc(15); expect_now("hold_pll_high", mk(1, 0, 0, 0, 0, loss));
    cyc(1);  expect_now("hold_pll_fall", mk(0, 0, 0, 0, 0, loss));
    cyc(64); expect_now("stab_not_ready", mk(0, 0, 0, 0, 0, loss));
    cyc(1);  expect_now("run_ready", mk(0, 1, 1, 0, 0, loss));
  endtask

  task automatic lose_relock(input int retry_before, input int loss_before, input int loss_after);
    locked = 1'b0;
    cyc(2); expect_now("loss_still_run", mk(0, 1, 1, 0, retry_before, loss_before));
    cyc(1); expect_now("loss_drop", mk(1, 0, 0, 0, 0, loss_after));
    bring_up(loss_after);
  endtask

  initial begin
    rst_n   = 1'b0;
    locked  = 1'b0;
    restart = 1'b0;
    n_vec   = 0;

    cyc(2);
    expect_now("reset_values", mk(1, 0, 0, 0, 0, 0));

    // Normal bring-up: lock 100 cycles after the PLL reset falls.
    rst_n = 1'b1;
    cyc(15);  expect_now("por_pll_high", mk(1, 0, 0, 0, 0, 0));
    cyc(1);   expect_now("por_pll_fall", mk(0, 0, 0, 0, 0, 0));
    cyc(100); expect_now("wait_lock", mk(0, 0, 0, 0, 0, 0));
    locked = 1'b1;
    cyc(66);  expect_now("edge65_not_ready", mk(0, 0, 0, 0, 0, 0));
    cyc(1);   expect_now("edge66_ready", mk(0, 1, 1, 0, 0, 0));

    lose_relock(0, 0, 1);

    // Restart coincident with a lock drop in RUN must not count a loss.
    locked = 1'b0; restart = 1'b1;
    cyc(1); restart = 1'b0;
    expect_now("restart_with_drop", mk(1, 0, 0, 0, 0, 1));
    bring_up(1);

    // Glitch 30 cycles into STABILIZE.
    restart = 1'b1; locked = 1'b0;
    cyc(1); restart = 1'b0;
    expect_now("glitch_restart", mk(1, 0, 0, 0, 0, 1));
    cyc(15); cyc(1);
    expect_now("glitch_wait_lock", mk(0, 0, 0, 0, 0, 1));
    locked = 1'b1;
    cyc(3); cyc(30);
    locked = 1'b0;
    cyc(3); expect_now("glitch_back_wait", mk(0, 0, 0, 0, 0, 1));
    locked = 1'b1;
    cyc(66); expect_now("glitch_full_stab", mk(0, 0, 0, 0, 0, 1));
    cyc(1);  expect_now("glitch_release", mk(0, 1, 1, 0, 0, 1));

    // Table: permanent no-lock to FAIL, restart, one timeout, then lock.
    add_vec(0, 1, 1, mk(1, 0, 0, 0, 0, 1));
    for (int w = 0; w < 4; w++) begin
      add_vec(0, 0, 15, mk(1, 0, 0, 0, w, 1));
      add_vec(0, 0, 1, mk(0, 0, 0, 0, w, 1));
      add_vec(0, 0, 4095, mk(0, 0, 0, 0, w, 1));
      if (w < 3) add_vec(0, 0, 1, mk(1, 0, 0, 0, w + 1, 1));
      else       add_vec(0, 0, 1, mk(1, 0, 0, 1, 3, 1));
    end
    add_vec(0, 0, 1000, mk(1, 0, 0, 1, 3, 1));
    add_vec(0, 1, 1, mk(1, 0, 0, 0, 0, 1));
    add_vec(0, 0, 15, mk(1, 0, 0, 0, 0, 1));
    add_vec(0, 0, 1, mk(0, 0, 0, 0, 0, 1));
    add_vec(0, 0, 4095, mk(0, 0, 0, 0, 0, 1));
    add_vec(0, 0, 1, mk(1, 0, 0, 0, 1, 1));
    add_vec(1, 0, 15, mk(1, 0, 0, 0, 1, 1));
    add_vec(1, 0, 1, mk(0, 0, 0, 0, 1, 1));
    add_vec(1, 0, 64, mk(0, 0, 0, 0, 1, 1));
    add_vec(1, 0, 1, mk(0, 1, 1, 0, 1, 1));
    for (int i = 0; i < n_vec; i++) begin
      locked  = vecs[i].locked;
      restart = vecs[i].restart;
      sb_q.push_back(vecs[i].exp);
      cyc(1);
      restart = 1'b0;
      cyc(int'(vecs[i].ncyc) - 1);
      compare($sformatf("vec%0d", i));
    end

    // Repeated lock losses; count saturates at 255 and retry clears.
    for (int i = 0; i < 256; i++) begin
      int lb, la;
      lb = (1 + i > 255) ? 255 : 1 + i;
      la = (2 + i > 255) ? 255 : 2 + i;
      lose_relock((i == 0) ? 1 : 0, lb, la);
    end

    // Asynchronous reset mid-RUN.
    #2 rst_n = 1'b0;
    #1 expect_now("async_rst_run", mk(1, 0, 0, 0, 0, 0));
    @(negedge clk); rst_n = 1'b1;
    bring_up(0);

    // Asynchronous reset mid-STABILIZE.
    restart = 1'b1;
    cyc(1); restart = 1'b0;
    expect_now("pre_stab_restart", mk(1, 0, 0, 0, 0, 0));
    cyc(15); cyc(1); cyc(30);
    #2 rst_n = 1'b0;
    #1 expect_now("async_rst_stab", mk(1, 0, 0, 0, 0, 0));
    @(negedge clk); rst_n = 1'b1;
    bring_up(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
